// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the bus-CPU control sequencer: opcodes, micro-step encodings
// and the bit layout of the internal (active-high) control word.
package control_sequencer_pkg;

  localparam int CS_NUM_STEPS = 5;
  localparam int CS_OPCODE_W  = 4;
  localparam int STEP_W       = $clog2(CS_NUM_STEPS);

  typedef enum logic [STEP_W-1:0] {T0, T1, T2, T3, T4} step_t;

  typedef logic [CS_OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_LDA = 4'h1;
  localparam opcode_t OP_ADD = 4'h2;
  localparam opcode_t OP_SUB = 4'h3;
  localparam opcode_t OP_STA = 4'h4;
  localparam opcode_t OP_LDI = 4'h5;
  localparam opcode_t OP_JMP = 4'h6;
  localparam opcode_t OP_JC  = 4'h7;
  localparam opcode_t OP_JZ  = 4'h8;
  localparam opcode_t OP_OUT = 4'hE;
  localparam opcode_t OP_HLT = 4'hF;

  // Every bit is active-high here; the top inverts the *_load_n strobes.
  localparam int CW_PC_OUT     = 0;
  localparam int CW_PC_INC     = 1;
  localparam int CW_PC_LOAD    = 2;
  localparam int CW_MAR_LOAD   = 3;
  localparam int CW_RAM_OUT    = 4;
  localparam int CW_RAM_WRITE  = 5;
  localparam int CW_IR_LOAD    = 6;
  localparam int CW_IR_OUT     = 7;
  localparam int CW_A_LOAD     = 8;
  localparam int CW_A_OUT      = 9;
  localparam int CW_B_LOAD     = 10;
  localparam int CW_ALU_OUT    = 11;
  localparam int CW_ALU_SUB    = 12;
  localparam int CW_FLAGS_LOAD = 13;
  localparam int CW_OUT_LOAD   = 14;
  localparam int CW_HLT        = 15;
  localparam int CW_W          = 16;

  typedef logic [CW_W-1:0] cw_t;

  function automatic cw_t cw_bit(input int idx);
    return cw_t'(1) << idx;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath registers (slave).
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  opcode_t             opcode;
  logic                carry_flag;
  logic                zero_flag;
  logic                pc_out;
  logic                pc_inc;
  logic                pc_load_n;
  logic                mar_load_n;
  logic                ram_out;
  logic                ram_write;
  logic                ir_load_n;
  logic                ir_out;
  logic                a_load_n;
  logic                a_out;
  logic                b_load_n;
  logic                alu_out;
  logic                alu_sub;
  logic                flags_load;
  logic                out_load_n;
  logic                halted;
  logic [STEP_W-1:0]   step;

  modport master (
    input  opcode, carry_flag, zero_flag,
    output pc_out, pc_inc, pc_load_n, mar_load_n, ram_out, ram_write,
           ir_load_n, ir_out, a_load_n, a_out, b_load_n, alu_out, alu_sub,
           flags_load, out_load_n, halted, step
  );

  modport slave (
    output opcode, carry_flag, zero_flag,
    input  pc_out, pc_inc, pc_load_n, mar_load_n, ram_out, ram_write,
           ir_load_n, ir_out, a_load_n, a_out, b_load_n, alu_out, alu_sub,
           flags_load, out_load_n, halted, step
  );

endinterface

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode: maps (step, opcode, flags) to one active-high control word.
// Each step has exactly one bus source, so the bus is never contended.
module microcode_rom
  import control_sequencer_pkg::*;
(
  input  step_t   step,
  input  opcode_t opcode,
  input  logic    carry_flag,
  input  logic    zero_flag,
  output cw_t     cw
);

  always_comb begin
    cw = '0;
    case (step)
      T0: cw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
      T1: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
      default: begin
        case (opcode)
          OP_LDA: begin
            case (step)
              T2:      cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
              T3:      cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
              default: ;
            endcase
          end
          OP_ADD, OP_SUB: begin
            case (step)
              T2:      cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
              T3:      cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
              T4:      cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD) | cw_bit(CW_FLAGS_LOAD);
              default: ;
            endcase
            // SUB holds the ALU in subtract mode from the B load onward
            if (opcode == OP_SUB && (step == T3 || step == T4))
              cw = cw | cw_bit(CW_ALU_SUB);
          end
          OP_STA: begin
            case (step)
              T2:      cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
              T3:      cw = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_WRITE);
              default: ;
            endcase
          end
          OP_LDI: if (step == T2) cw = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
          OP_JMP: if (step == T2) cw = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
          OP_JC:  if (step == T2 && carry_flag) cw = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
          OP_JZ:  if (step == T2 && zero_flag)  cw = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
          OP_OUT: if (step == T2) cw = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
          OP_HLT: if (step == T2) cw = cw_bit(CW_HLT);
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step counter plus active/halt state; gates the microcode word onto the strobes.
// Strobes are combinational so an async reset silences them without a clock edge.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NUM_STEPS = CS_NUM_STEPS,
  parameter int OPCODE_W  = CS_OPCODE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  control_sequencer_if.master  bus
);

  localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

  step_t               step;
  logic                active;
  logic                halted;
  logic [OPCODE_W-1:0] opcode;
  cw_t                 cw_raw;
  cw_t                 cw;

  assign opcode = bus.opcode;

  microcode_rom u_rom (
    .step       (step),
    .opcode     (opcode),
    .carry_flag (bus.carry_flag),
    .zero_flag  (bus.zero_flag),
    .cw         (cw_raw)
  );

  assign cw = (active && !halted) ? cw_raw : '0;

  // active lags reset release by one edge; HLT freezes the counter where it stands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step   <= T0;
      active <= 1'b0;
      halted <= 1'b0;
    end else if (!active) begin
      active <= 1'b1;
    end else if (!halted) begin
      if (cw[CW_HLT])
        halted <= 1'b1;
      else
        step <= (step == LAST_STEP) ? T0 : step_t'(step + 1'b1);
    end
  end

  assign bus.pc_out     =  cw[CW_PC_OUT];
  assign bus.pc_inc     =  cw[CW_PC_INC];
  assign bus.pc_load_n  = ~cw[CW_PC_LOAD];
  assign bus.mar_load_n = ~cw[CW_MAR_LOAD];
  assign bus.ram_out    =  cw[CW_RAM_OUT];
  assign bus.ram_write  =  cw[CW_RAM_WRITE];
  assign bus.ir_load_n  = ~cw[CW_IR_LOAD];
  assign bus.ir_out     =  cw[CW_IR_OUT];
  assign bus.a_load_n   = ~cw[CW_A_LOAD];
  assign bus.a_out      =  cw[CW_A_OUT];
  assign bus.b_load_n   = ~cw[CW_B_LOAD];
  assign bus.alu_out    =  cw[CW_ALU_OUT];
  assign bus.alu_sub    =  cw[CW_ALU_SUB];
  assign bus.flags_load =  cw[CW_FLAGS_LOAD];
  assign bus.out_load_n = ~cw[CW_OUT_LOAD];
  assign bus.halted     =  halted;
  assign bus.step       =  step;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: a bus-transfer reference model predicts every cycle's strobes,
// and a negedge monitor compares them against the sequencer.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  control_sequencer_if bus();

  control_sequencer #(.NUM_STEPS(5), .OPCODE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_out, pc_inc, pc_load_n, mar_load_n, ram_out, ram_write, ir_load_n, ir_out;
    logic a_load_n, a_out, b_load_n, alu_out, alu_sub, flags_load, out_load_n, halted;
    logic [2:0] step;
  } obs_t;

  obs_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  int         m_step = 0;
  bit         m_act = 0, m_hlt = 0;
  logic [3:0] cur_op = 4'h0;

  // Sources: 1 PC, 2 RAM, 3 IR, 4 A, 5 ALU. Destinations: 1 PC, 2 MAR, 3 IR, 4 A, 5 B, 6 OUT, 7 RAM.
  function automatic obs_t model(input bit rst, input int st, input bit act, input bit hlt,
                                 input logic [3:0] op, input bit c, input bit z);
    obs_t o;
    int src, dst;
    o = '0;
    {o.pc_load_n, o.mar_load_n, o.ir_load_n, o.a_load_n, o.b_load_n, o.out_load_n} = '1;
    if (!rst) return o;
    o.step   = 3'(st);
    o.halted = hlt;
    if (!act || hlt) return o;
    src = 0; dst = 0;
    if (st == 0) begin src = 1; dst = 2; end
    else if (st == 1) begin src = 2; dst = 3; o.pc_inc = 1; end
    else begin
      case (op)
        4'h1: if (st == 2) begin src = 3; dst = 2; end
              else if (st == 3) begin src = 2; dst = 4; end
        4'h2, 4'h3: begin
          if (st == 2) begin src = 3; dst = 2; end
          if (st == 3) begin src = 2; dst = 5; end
          if (st == 4) begin src = 5; dst = 4; o.flags_load = 1; end
          if (op == 4'h3 && st >= 3) o.alu_sub = 1;
        end
        4'h4: if (st == 2) begin src = 3; dst = 2; end
              else if (st == 3) begin src = 4; dst = 7; end
        4'h5: if (st == 2) begin src = 3; dst = 4; end
        4'h6: if (st == 2) begin src = 3; dst = 1; end
        4'h7: if (st == 2 && c) begin src = 3; dst = 1; end
        4'h8: if (st == 2 && z) begin src = 3; dst = 1; end
        4'hE: if (st == 2) begin src = 4; dst = 6; end
        default: ;
      endcase
    end
    case (src)
      1: o.pc_out = 1;
      2: o.ram_out = 1;
      3: o.ir_out = 1;
      4: o.a_out = 1;
      5: o.alu_out = 1;
      default: ;
    endcase
    case (dst)
      1: o.pc_load_n = 0;
      2: o.mar_load_n = 0;
      3: o.ir_load_n = 0;
      4: o.a_load_n = 0;
      5: o.b_load_n = 0;
      6: o.out_load_n = 0;
      7: o.ram_write = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {bus.pc_out, bus.pc_inc, bus.pc_load_n, bus.mar_load_n, bus.ram_out, bus.ram_write,
         bus.ir_load_n, bus.ir_out, bus.a_load_n, bus.a_out, bus.b_load_n, bus.alu_out,
         bus.alu_sub, bus.flags_load, bus.out_load_n, bus.halted, bus.step};
    return o;
  endfunction

  // One clock: advance the model across the edge, then drive this cycle's inputs.
  task automatic tick(input bit r, input logic [3:0] op, input bit c, input bit z);
    @(posedge clk);
    if (!rst_n) begin m_step = 0; m_act = 0; m_hlt = 0; end
    else if (!m_act) m_act = 1;
    else if (!m_hlt) begin
      if (m_step == 2 && cur_op == 4'hF) m_hlt = 1;
      else m_step = (m_step + 1) % 5;
    end
    #1;
    rst_n = r;
    bus.opcode = op; bus.carry_flag = c; bus.zero_flag = z;
    cur_op = op;
    if (!r) begin m_step = 0; m_act = 0; m_hlt = 0; end
    expq.push_back(model(r, m_step, m_act, m_hlt, op, c, z));
  endtask

  task automatic run_instr(input logic [3:0] op, input bit c, input bit z, input bit rnd);
    for (int i = 0; i < 5; i++)
      if (rnd) tick(1, op, 1'($urandom), 1'($urandom));
      else     tick(1, op, c, z);
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    int drv;
    cyc++;
    a = sample();
    drv = int'(a.pc_out) + int'(a.ram_out) + int'(a.ir_out) + int'(a.a_out) + int'(a.alu_out);
    checks++;
    if (drv > 1 || (a.pc_out && !a.pc_load_n) || (a.ir_out && !a.ir_load_n) ||
        (a.a_out && !a.a_load_n) || (a.ram_out && a.ram_write)) begin
      failures++;
      $display("FAIL bus_drivers cyc=%0d drivers=%0d got=%h required at most one non-self driver",
               cyc, drv, a);
    end
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL strobes cyc=%0d step=%0d op=%h got=%h exp=%h", cyc, a.step, bus.opcode, a, e);
      end
    end
  end

  logic [3:0] dir_op [17] = '{4'h5, 4'h2, 4'h3, 4'h7, 4'h7, 4'h8, 4'h8, 4'h1, 4'h4,
                              4'h6, 4'hE, 4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
  bit         dir_c  [17] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  bit         dir_z  [17] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    obs_t a, idle;
    bus.opcode = 4'h0; bus.carry_flag = 1'b0; bus.zero_flag = 1'b0;
    repeat (3) tick(0, 4'h0, 0, 0);
    tick(1, 4'h0, 0, 0);

    for (int i = 0; i < 17; i++) run_instr(dir_op[i], dir_c[i], dir_z[i], 0);
    for (int i = 0; i < 200; i++) run_instr(4'($urandom_range(0, 14)), 0, 0, 1);

    // Reset asserted between edges during T3 of an ADD
    for (int i = 0; i < 4; i++) tick(1, 4'h2, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    m_step = 0; m_act = 0; m_hlt = 0;
    #1;
    a = sample();
    idle = model(0, 0, 0, 0, 4'h0, 0, 0);
    checks++;
    if (a !== idle) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", a, idle);
    end
    tick(0, 4'h2, 0, 0);
    tick(1, 4'h2, 0, 0);
    run_instr(4'h2, 0, 0, 0);
    run_instr(4'h3, 0, 0, 1);

    run_instr(4'hF, 0, 0, 0);
    repeat (20) tick(1, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
    tick(0, 4'h0, 0, 0);
    tick(1, 4'h5, 0, 0);
    run_instr(4'h5, 0, 0, 0);
    run_instr(4'h0, 0, 0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
